// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite alpha source pipeline.
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } texel_t;

  localparam logic [7:0] ALPHA_BG_ONLY = 8'hFF;

  localparam int unsigned TEX_R_OFF = 24;
  localparam int unsigned TEX_G_OFF = 16;
  localparam int unsigned TEX_B_OFF = 8;
  localparam int unsigned TEX_A_OFF = 0;

  function automatic texel_t unpack_texel(input logic [31:0] word);
    texel_t t;
    t.r = word[TEX_R_OFF +: 8];
    t.g = word[TEX_G_OFF +: 8];
    t.b = word[TEX_B_OFF +: 8];
    t.a = word[TEX_A_OFF +: 8];
    return t;
  endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// Combinational sprite hit test and texel address generation.
module sprite_hit_addr
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = 32,
  parameter int unsigned SPR_H  = 32,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              enable,
  input  logic [X_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  input  logic [X_W-1:0]    pos_x,
  input  logic [Y_W-1:0]    pos_y,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned XB = $clog2(SPR_W);

  logic [X_W:0] w_dx;
  logic [Y_W:0] w_dy;

  // One extra bit keeps the difference signed, so positions near the
  // coordinate maximum clip instead of wrapping onto the left/top edge.
  always_comb begin
    w_dx = {1'b0, pix_x} - {1'b0, pos_x};
    w_dy = {1'b0, pix_y} - {1'b0, pos_y};
    hit  = enable && !w_dx[X_W] && !w_dy[Y_W] &&
           (w_dx < (X_W + 1)'(SPR_W)) && (w_dy < (Y_W + 1)'(SPR_H));
    addr = ADDR_W'({w_dy[Y_W-1:0], w_dx[XB-1:0]});
  end

endmodule

// File: rtl/sprite_alpha_source.sv
// Pipelined single-sprite source: hit test, ROM fetch, RGB + background alpha.
// Optional colour-key transparency is enabled by defining SPRITE_COLORKEY_EN.
module sprite_alpha_source
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W        = 32,
  parameter int unsigned SPR_H        = 32,
  parameter int unsigned X_W          = 10,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [23:0] COLORKEY_RGB = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pos_wr,
  input  logic [X_W-1:0]    pos_x_in,
  input  logic [Y_W-1:0]    pos_y_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [X_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  input  logic              pix_eof,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        sprite_R,
  output logic [7:0]        sprite_G,
  output logic [7:0]        sprite_B,
  output logic [7:0]        alpha,
  output logic              out_eof
);

  logic [X_W-1:0]    r_pos_x, r_pend_x;
  logic [Y_W-1:0]    r_pos_y, r_pend_y;
  logic              r_pend_flag;
  logic              r_s1_valid, r_s1_hit, r_s1_eof;
  logic              r_out_valid, r_out_eof;
  logic [7:0]        r_out_r, r_out_g, r_out_b, r_out_a;

  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;
  logic              w_accept;
  logic              w_eof_acc;
  logic              w_s1_hit;
  texel_t            w_texel;

  sprite_hit_addr #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_hit_addr (
    .enable (enable),
    .pix_x  (pix_x),
    .pix_y  (pix_y),
    .pos_x  (r_pos_x),
    .pos_y  (r_pos_y),
    .hit    (w_hit),
    .addr   (w_addr)
  );

  assign pix_ready = !r_out_valid || out_ready;
  assign rom_en    = pix_ready;
  assign w_accept  = pix_valid && pix_ready;
  assign w_eof_acc = w_accept && pix_eof;
  assign rom_addr  = (w_accept && w_hit) ? w_addr : '0;

  // Position takes effect only at a frame boundary so no frame is torn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_flag <= 1'b0;
    end else if (w_eof_acc) begin
      if (pos_wr) begin
        r_pos_x <= pos_x_in;
        r_pos_y <= pos_y_in;
      end else if (r_pend_flag) begin
        r_pos_x <= r_pend_x;
        r_pos_y <= r_pend_y;
      end
      r_pend_flag <= 1'b0;
    end else if (pos_wr) begin
      r_pend_x    <= pos_x_in;
      r_pend_y    <= pos_y_in;
      r_pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else if (pix_ready) begin
      r_s1_valid <= pix_valid;
      r_s1_hit   <= pix_valid && w_hit;
      r_s1_eof   <= pix_valid && pix_eof;
    end
  end

  assign w_texel = unpack_texel(rom_data);

`ifdef SPRITE_COLORKEY_EN
  assign w_s1_hit = r_s1_hit && ({w_texel.r, w_texel.g, w_texel.b} != COLORKEY_RGB);
`else
  assign w_s1_hit = r_s1_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_r     <= 8'h00;
      r_out_g     <= 8'h00;
      r_out_b     <= 8'h00;
      r_out_a     <= ALPHA_BG_ONLY;
    end else if (pix_ready) begin
      r_out_valid <= r_s1_valid;
      r_out_eof   <= r_s1_eof;
      if (w_s1_hit) begin
        r_out_r <= w_texel.r;
        r_out_g <= w_texel.g;
        r_out_b <= w_texel.b;
        r_out_a <= w_texel.a;
      end else begin
        r_out_r <= 8'h00;
        r_out_g <= 8'h00;
        r_out_b <= 8'h00;
        r_out_a <= ALPHA_BG_ONLY;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_eof   = r_out_eof;
  assign sprite_R  = r_out_r;
  assign sprite_G  = r_out_g;
  assign sprite_B  = r_out_b;
  assign alpha     = r_out_a;

endmodule

// File: tb/tb_sprite_alpha_source.sv
// Self-checking bench for sprite_alpha_source (honours SPRITE_COLORKEY_EN).
module tb_sprite_alpha_source;

  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              pos_wr;
  logic [X_W-1:0]    pos_x_in;
  logic [Y_W-1:0]    pos_y_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_eof;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        sprite_R, sprite_G, sprite_B, alpha;
  logic              out_eof;

  sprite_alpha_source dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pos_wr    (pos_wr),
    .pos_x_in  (pos_x_in),
    .pos_y_in  (pos_y_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_eof   (pix_eof),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sprite_R  (sprite_R),
    .sprite_G  (sprite_G),
    .sprite_B  (sprite_B),
    .alpha     (alpha),
    .out_eof   (out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  initial rom_data = 32'h0;
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tex_fn(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a ^ 8'h5A, 8'(i >> 2), a + 8'd1, ~a};
  endfunction

  // Expected {R,G,B,alpha} for a pixel
  function automatic logic [31:0] exp_out(input bit hit, input int addr);
    logic [31:0] t;
    if (!hit) return 32'h0000_00FF;
    t = mem[addr];
`ifdef SPRITE_COLORKEY_EN
    if (t[31:8] == 24'hFF00FF) return 32'h0000_00FF;
`endif
    return t;
  endfunction

  typedef struct {
    int x;
    int y;
    bit en;
    bit eof;
    bit wr;
    int wx;
    int wy;
    bit hit;
    int addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int x, input int y, input bit en, input bit eof, input bit wr,
                         input int wx, input int wy, input bit hit, input int addr);
    vec_t v;
    v.x = x; v.y = y; v.en = en; v.eof = eof; v.wr = wr;
    v.wx = wx; v.wy = wy; v.hit = hit; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
    pos_wr    = 1'b0;
    enable    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    int got;
    logic [31:0] expq[$];
    logic [33:0] snap;
    logic [33:0] cur;
    bit stalled_prev;
    bit any_valid;

    for (int i = 0; i < 1024; i++) mem[i] = tex_fn(i);
    mem[67] = 32'h11223344;
    mem[5]  = 32'hFF00FF10;

    reset = 1'b1; out_ready = 1'b1;
    pos_x_in = '0; pos_y_in = '0; pix_x = '0; pix_y = '0;
    idle_inputs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_eof", 64'(out_eof), 64'(0));
    chk("reset_rgb", 64'({sprite_R, sprite_G, sprite_B}), 64'(0));
    chk("reset_alpha", 64'(alpha), 64'hFF);
    chk("reset_rom_addr", 64'(rom_addr), 64'(0));
    chk("reset_pix_ready", 64'(pix_ready), 64'(1));
    @(posedge clk); #1 reset = 1'b0;

    //      x     y   en eof wr  wx    wy  hit addr
    add_vec(0,    0,  1, 1,  1,  100,  50, 1,  0);     // move applied at once with eof
    add_vec(103,  52, 1, 0,  0,  0,    0,  1,  67);
    add_vec(99,   52, 1, 0,  0,  0,    0,  0,  0);
    add_vec(100,  50, 1, 0,  0,  0,    0,  1,  0);
    add_vec(131,  81, 1, 0,  0,  0,    0,  1,  1023);
    add_vec(132,  50, 1, 0,  0,  0,    0,  0,  0);
    add_vec(100,  82, 1, 0,  0,  0,    0,  0,  0);
    add_vec(100,  49, 1, 0,  0,  0,    0,  0,  0);
    add_vec(103,  52, 0, 0,  0,  0,    0,  0,  0);
    add_vec(105,  50, 1, 0,  0,  0,    0,  1,  5);
    add_vec(103,  52, 1, 1,  1,  1020, 0,  1,  67);
    add_vec(2,    0,  1, 0,  0,  0,    0,  0,  0);     // must clip, not wrap
    add_vec(1023, 0,  1, 0,  0,  0,    0,  1,  3);
    add_vec(1019, 0,  1, 0,  0,  0,    0,  0,  0);
    add_vec(5,    5,  1, 0,  1,  7,    7,  0,  0);
    add_vec(0,    0,  1, 0,  1,  0,    0,  0,  0);
    add_vec(1,    1,  1, 1,  0,  0,    0,  0,  0);
    add_vec(0,    0,  1, 0,  0,  0,    0,  1,  0);
    add_vec(33,   1,  1, 0,  0,  0,    0,  0,  0);
    add_vec(31,   31, 1, 0,  0,  0,    0,  1,  1023);

    n = vecs.size();
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i < n) begin
        pix_valid = 1'b1;
        pix_x     = X_W'(vecs[i].x);
        pix_y     = Y_W'(vecs[i].y);
        enable    = vecs[i].en;
        pix_eof   = vecs[i].eof;
        pos_wr    = vecs[i].wr;
        pos_x_in  = X_W'(vecs[i].wx);
        pos_y_in  = Y_W'(vecs[i].wy);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i < n)
        chk($sformatf("vec%0d_rom_addr", i), 64'(rom_addr),
            64'(vecs[i].hit ? vecs[i].addr : 0));
      if (i >= 2)
        chk($sformatf("vec%0d_out", i - 2),
            64'({out_valid, out_eof, sprite_R, sprite_G, sprite_B, alpha}),
            64'({1'b1, vecs[i-2].eof, exp_out(vecs[i-2].hit, vecs[i-2].addr)}));
    end

    // Backpressure: continuous stream at position (0,0), out_ready low 5 cycles
    idx = 0; got = 0; stalled_prev = 1'b0; snap = '0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c < 9);
      pix_valid = (idx < 12);
      pix_x     = X_W'(idx);
      pix_y     = '0;
      pix_eof   = 1'b0;
      pos_wr    = 1'b0;
      enable    = 1'b1;
      @(negedge clk);
      cur = {out_valid, out_eof, sprite_R, sprite_G, sprite_B, alpha};
      if (out_valid && !out_ready) chk("bp_pix_ready_low", 64'(pix_ready), 64'(0));
      if (stalled_prev) chk("bp_output_stable", 64'(cur), 64'(snap));
      stalled_prev = out_valid && !out_ready;
      snap = cur;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          errors++; checks++;
          $display("FAIL bp_extra_output: got %h expected none", cur);
        end else begin
          chk($sformatf("bp_pixel%0d", got), 64'({sprite_R, sprite_G, sprite_B, alpha}),
              64'(expq.pop_front()));
          got++;
        end
      end
      if (pix_valid && pix_ready) begin
        expq.push_back(exp_out(1'b1, idx));
        idx++;
      end
      if (got == 12 && idx == 12 && c > 12) break;
    end
    chk("bp_all_delivered", 64'(got), 64'(12));
    chk("bp_queue_empty", 64'(expq.size()), 64'(0));
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset with pixels in flight
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_x = 10'd3; pix_y = '0;
    @(posedge clk); #1;
    pix_x = 10'd4;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_alpha", 64'(alpha), 64'hFF);
    chk("rst_mid_rgb", 64'({sprite_R, sprite_G, sprite_B}), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    any_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    chk("rst_mid_no_stale", 64'(any_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
